// File: rtl/branch_unit.sv
// Branch/call/return control feeding the PC: jump LUT plus return stack.
// Ports: clk, reset (async low), op/lut_idx/zero_flag/prog_ctr/stall in; LUT write port; jump_en/target, RAS status out.
module branch_unit #(
  parameter int D           = 8,
  parameter int LUT_AW      = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2:0]                         op,
  input  logic [LUT_AW-1:0]                  lut_idx,
  input  logic                               zero_flag,
  input  logic [D-1:0]                       prog_ctr,
  input  logic                               stall,
  input  logic                               lut_we,
  input  logic [LUT_AW-1:0]                  lut_waddr,
  input  logic [D-1:0]                       lut_wdata,
  output logic                               jump_en,
  output logic [D-1:0]                       target,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   ras_depth,
  output logic                               ras_overflow,
  output logic                               ras_underflow
);

  localparam int DW  = $clog2(STACK_DEPTH+1);
  localparam int SAW = (STACK_DEPTH > 1) ?
                       $clog2(STACK_DEPTH) : 1;
  localparam int LN  = 2**LUT_AW;

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b010;
  localparam logic [2:0] OP_BNE  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic [D-1:0]   lut [LN];
  logic [D-1:0]   ras [STACK_DEPTH];
  logic [DW-1:0]  depth;
  logic           ovf;
  logic           unf;

  logic           act;
  logic           full;
  logic           empty;
  logic [SAW-1:0] top_idx;
  logic [SAW-1:0] push_idx;
  logic [D-1:0]   lut_rd;
  logic [D-1:0]   top;
  logic [D-1:0]   ret_addr;

  logic           is_jmp;
  logic           is_beq;
  logic           is_bne;
  logic           is_call;
  logic           is_ret;

  logic           jen;
  logic           push;
  logic           pop;
  logic           set_ovf;
  logic           set_unf;

  // Outputs are forced idle while reset is held.
  assign act      = reset && !stall;
  assign full     = (depth == FULL);
  assign empty    = (depth == '0);
  assign top_idx  = SAW'(depth - DW'(1));
  assign push_idx = SAW'(depth);
  assign lut_rd   = lut[lut_idx];
  assign top      = ras[top_idx];
  assign ret_addr = prog_ctr + D'(1);

  assign is_jmp  = act && (op == OP_JMP);
  assign is_beq  = act && (op == OP_BEQ);
  assign is_bne  = act && (op == OP_BNE);
  assign is_call = act && (op == OP_CALL);
  assign is_ret  = act && (op == OP_RET);

  always_comb begin
    jen     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    unique case (1'b1)
      is_jmp:  jen = 1'b1;
      is_beq:  jen = zero_flag;
      is_bne:  jen = !zero_flag;
      is_call: begin
        jen     = !full;
        push    = !full;
        set_ovf = full;
      end
      is_ret: begin
        jen     = !empty;
        pop     = !empty;
        set_unf = empty;
      end
      default: jen = 1'b0;
    endcase
  end

  assign jump_en = jen;

  always_comb begin
    target = '0;
    if (jen) target = is_ret ? top : lut_rd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LN; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STACK_DEPTH; i++)
        ras[i] <= '0;
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (push) begin
        ras[push_idx] <= ret_addr;
        depth         <= depth + DW'(1);
      end
      if (pop) depth <= depth - DW'(1);
      if (set_ovf) ovf <= 1'b1;
      if (set_unf) unf <= 1'b1;
    end
  end

  assign ras_depth     = depth;
  assign ras_overflow  = ovf;
  assign ras_underflow = unf;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit with a queue-based reference model.
// Ports: none; drives clk/reset and all DUT inputs.
module tb_branch_unit;

  localparam int D  = 8;
  localparam int AW = 4;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    op = '0;
  logic [AW-1:0] lut_idx = '0;
  logic          zero_flag = 1'b0;
  logic [D-1:0]  prog_ctr = '0;
  logic          stall = 1'b0;
  logic          lut_we = 1'b0;
  logic [AW-1:0] lut_waddr = '0;
  logic [D-1:0]  lut_wdata = '0;
  logic          jump_en;
  logic [D-1:0]  target;
  logic [2:0]    ras_depth;
  logic          ras_overflow;
  logic          ras_underflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [D-1:0] lut_m [16];
  logic [D-1:0] ras_m [$];
  logic         ovf_m = 1'b0;
  logic         unf_m = 1'b0;

  branch_unit #(.D(D), .LUT_AW(AW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .op(op),
    .lut_idx(lut_idx), .zero_flag(zero_flag),
    .prog_ctr(prog_ctr), .stall(stall),
    .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .jump_en(jump_en),
    .target(target), .ras_depth(ras_depth),
    .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, got, exp);
    end
  endtask

  function automatic void clear_model();
    for (int i = 0; i < 16; i++) lut_m[i] = '0;
    ras_m.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endfunction

  // Expected combinational outputs from model state.
  function automatic logic [8:0] expect_out();
    logic j;
    logic [D-1:0] t;
    j = 1'b0;
    t = '0;
    if (reset && !stall) begin
      case (op)
        3'd1: begin j = 1'b1; t = lut_m[lut_idx]; end
        3'd2: begin j = zero_flag; t = lut_m[lut_idx]; end
        3'd3: begin j = !zero_flag; t = lut_m[lut_idx]; end
        3'd4: begin
          j = (ras_m.size() < SD);
          t = lut_m[lut_idx];
        end
        3'd5: begin
          j = (ras_m.size() > 0);
          if (j) t = ras_m[ras_m.size()-1];
        end
        default: j = 1'b0;
      endcase
    end
    if (!j) t = '0;
    return {j, t};
  endfunction

  always @(negedge reset) clear_model();

  always @(posedge clk) begin
    if (reset) begin
      if (!stall) begin
        if (op == 3'd4) begin
          if (ras_m.size() == SD) ovf_m = 1'b1;
          else ras_m.push_back(prog_ctr + 8'd1);
        end else if (op == 3'd5) begin
          if (ras_m.size() == 0) unf_m = 1'b1;
          else void'(ras_m.pop_back());
        end
      end
      if (lut_we) lut_m[lut_waddr] = lut_wdata;
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    #2;
    if (chk_en) begin
      e = expect_out();
      chk("m_jump_en", 32'(jump_en), 32'(e[8]));
      chk("m_target", 32'(target), 32'(e[7:0]));
      chk("m_depth", 32'(ras_depth), 32'(ras_m.size()));
      chk("m_ovf", 32'(ras_overflow), 32'(ovf_m));
      chk("m_unf", 32'(ras_underflow), 32'(unf_m));
    end
  end

  task automatic drive(input logic [2:0] o,
                       input logic [3:0] idx,
                       input logic zf,
                       input logic [7:0] pc,
                       input logic st,
                       input logic we,
                       input logic [3:0] wa,
                       input logic [7:0] wd);
    @(negedge clk);
    op = o; lut_idx = idx; zero_flag = zf;
    prog_ctr = pc; stall = st; lut_we = we;
    lut_waddr = wa; lut_wdata = wd;
    #3;
  endtask

  task automatic idle();
    drive(3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  initial begin
    clear_model();
    op = 3'd1;
    #7;
    chk("rst_jump_en", 32'(jump_en), 32'd0);
    chk("rst_target", 32'(target), 32'd0);
    chk("rst_depth", 32'(ras_depth), 32'd0);
    chk("rst_flags", 32'({ras_overflow, ras_underflow}),
        32'd0);
    @(negedge clk);
    reset = 1'b1;
    op = 3'd0;
    chk_en = 1'b1;

    drive(3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd3, 8'h40);
    drive(3'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd5, 8'h90);
    drive(3'd1, 4'd3, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("jmp_en", 32'(jump_en), 32'd1);
    chk("jmp_tgt", 32'(target), 32'h40);
    drive(3'd1, 4'd3, 1'b0, 8'h00, 1'b0, 1'b1, 4'd3, 8'h41);
    chk("wr_old", 32'(target), 32'h40);
    drive(3'd1, 4'd3, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("wr_new", 32'(target), 32'h41);

    drive(3'd2, 4'd5, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("beq_t", 32'({jump_en, target}), 32'h190);
    drive(3'd2, 4'd5, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("beq_nt", 32'({jump_en, target}), 32'h000);
    drive(3'd3, 4'd5, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("bne_t", 32'({jump_en, target}), 32'h190);
    drive(3'd7, 4'd5, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("op7", 32'(jump_en), 32'd0);

    drive(3'd4, 4'd5, 1'b0, 8'h10, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("call1_tgt", 32'({jump_en, target}), 32'h190);
    drive(3'd4, 4'd5, 1'b0, 8'h42, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("call1_depth", 32'(ras_depth), 32'd1);
    drive(3'd4, 4'd5, 1'b0, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("call2_depth", 32'(ras_depth), 32'd2);
    drive(3'd5, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("call3_depth", 32'(ras_depth), 32'd3);
    chk("ret1", 32'({jump_en, target}), 32'h100);
    drive(3'd5, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("ret2", 32'({jump_en, target}), 32'h143);
    drive(3'd5, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("ret3", 32'({jump_en, target}), 32'h111);
    idle();
    chk("ret_depth0", 32'(ras_depth), 32'd0);

    for (int i = 0; i < 5; i++) begin
      drive(3'd4, 4'd5, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0,
            4'd0, 8'h00);
      if (i == 4) chk("call5_en", 32'(jump_en), 32'd0);
    end
    idle();
    chk("ovf_set", 32'(ras_overflow), 32'd1);
    chk("ovf_depth", 32'(ras_depth), 32'd4);

    for (int i = 0; i < 5; i++) begin
      drive(3'd5, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
      if (i == 0) chk("pop_top", 32'(target), 32'h24);
      if (i == 4) chk("ret5_en", 32'(jump_en), 32'd0);
    end
    idle();
    chk("unf_set", 32'(ras_underflow), 32'd1);
    chk("unf_depth", 32'(ras_depth), 32'd0);
    chk("ovf_sticky", 32'(ras_overflow), 32'd1);

    drive(3'd4, 4'd5, 1'b0, 8'h30, 1'b1, 1'b1, 4'd7, 8'h77);
    chk("stall_en", 32'(jump_en), 32'd0);
    drive(3'd1, 4'd7, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("stall_lut", 32'(target), 32'h77);
    chk("stall_depth", 32'(ras_depth), 32'd0);
    drive(3'd4, 4'd7, 1'b0, 8'h30, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("unstall_call", 32'({jump_en, target}), 32'h177);
    drive(3'd4, 4'd7, 1'b0, 8'h31, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("unstall_depth", 32'(ras_depth), 32'd1);

    drive(3'd1, 4'd7, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("pre_rst_depth", 32'(ras_depth), 32'd2);
    chk("pre_rst_ovf", 32'(ras_overflow), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_depth", 32'(ras_depth), 32'd0);
    chk("arst_flags", 32'({ras_overflow, ras_underflow}),
        32'd0);
    chk("arst_jump", 32'({jump_en, target}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(3'd5, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("post_ret_en", 32'(jump_en), 32'd0);
    idle();
    chk("post_unf", 32'(ras_underflow), 32'd1);
    idle();
    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Control stage directly upstream of the program counter: decodes branch/call/return requests and drives the counter's jump_en and target inputs.
- The counter loads target at the clock edge where jump_en is high; otherwise it increments.
- Holds a programmable jump-target lookup table (LUT), written by the loader before execution.
- Holds a return-address stack (RAS) for call/ret.

Parameters:
- D, 8, program-counter / target width in bits.
- LUT_AW, 4, LUT index width; table holds 2**LUT_AW entries.
- STACK_DEPTH, 4, number of RAS entries (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- op  input  3  branch opcode: 000 none, 001 jmp, 010 beq, 011 bne, 100 call, 101 ret; 110/111 treated as none.
- lut_idx  input  LUT_AW  LUT entry selecting the target for jmp/beq/bne/call.
- zero_flag  input  1  ALU zero flag for beq/bne.
- prog_ctr  input  D  current counter value.
- stall  input  1  pipeline hold; suppresses all branch actions.
- lut_we  input  1  LUT write enable.
- lut_waddr  input  LUT_AW  LUT write address.
- lut_wdata  input  D  LUT write data.
- jump_en  output  1  to counter jump_en.
- target  output  D  to counter target.
- ras_depth  output  $clog2(STACK_DEPTH+1)  current RAS occupancy.
- ras_overflow  output  1  sticky: call attempted with RAS full.
- ras_underflow  output  1  sticky: ret attempted with RAS empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - all LUT entries = 0; RAS entries = 0; ras_depth = 0.
  - ras_overflow = 0; ras_underflow = 0.
  - jump_en = 0, target = 0 for as long as reset is asserted.
- jump_en/target are combinational from op, lut_idx, zero_flag, stall and registered state. This gives zero added latency: the counter takes the branch at the next rising edge.
- When jump_en=0, target = 0.
- LUT:
  - Synchronous write at posedge when lut_we=1, independent of stall and op.
  - Reads are asynchronous.
  - Same-cycle read of an address being written returns the OLD value; the new value is visible from the next cycle.
- Per cycle with stall=0:
  - none / 110 / 111: jump_en=0; no state change.
  - jmp: jump_en=1, target=LUT[lut_idx].
  - beq: jump_en=zero_flag, target=LUT[lut_idx] when taken.
  - bne: jump_en=~zero_flag, target=LUT[lut_idx] when taken.
  - call, RAS not full: jump_en=1, target=LUT[lut_idx]. At posedge, push (prog_ctr+1) mod 2**D; ras_depth increments.
  - call, RAS full: jump_en=0 (falls through); no push; ras_overflow set at posedge.
  - ret, RAS not empty: jump_en=1, target=top entry. At posedge, pop; ras_depth decrements.
  - ret, RAS empty: jump_en=0; ras_underflow set at posedge; ras_depth stays 0.
- stall=1: jump_en=0; RAS, depth and error flags unchanged; LUT write still honoured.
- Arithmetic: return address = prog_ctr+1, truncated to D bits (8'hFF -> 8'h00).
- RAS is LIFO; top = most recent push. Entries above depth are don't-care and never observable.
- Error flags are cleared only by reset.
- Reset asserted mid-sequence: state clears immediately, with no dependence on the clock.

Test Plan:
- Reset then LUT load: write LUT[3]=8'h40 and LUT[5]=8'h90. Then op=jmp, lut_idx=3 -> jump_en=1, target=8'h40. Same-cycle write of LUT[3]=8'h41 while reading it -> target=8'h40, then 8'h41 next cycle.
- Conditionals, LUT[5]=8'h90: beq with zero_flag=1 -> jump_en=1, target=8'h90. beq with zero_flag=0 -> jump_en=0. bne with zero_flag=0 -> jump_en=1. op=3'b111 -> jump_en=0.
- Call/ret nesting, STACK_DEPTH=4:
  - call at prog_ctr=8'h10, 8'h42, 8'hFF -> ras_depth 1,2,3.
  - three rets -> targets 8'h00, 8'h43, 8'h11 in order; ras_depth back to 0.
- RAS boundaries:
  - 5 calls -> 5th gives jump_en=0, ras_overflow=1, ras_depth=4.
  - 5 rets -> 5th gives jump_en=0, ras_underflow=1, ras_depth=0.
  - both flags stay 1 until reset.
- Stall: op=call with stall=1 and lut_we=1 -> jump_en=0, ras_depth unchanged, LUT entry updated. Releasing stall -> call proceeds normally.
- Async reset mid-operation: with ras_depth=2 and ras_overflow=1, drop reset between clock edges -> ras_depth=0, flags=0, jump_en=0 immediately. After release, ret -> ras_underflow=1.
